// File: rtl/clean_scheduler.sv
// Cleaning-resource sequencer for the range hood: fan working-time accumulator, clean threshold,
// standby warning and timed self-clean cycle. Outputs are registered; no backpressure (pulse inputs).
module clean_scheduler #(
  parameter logic [5:0] DEF_HOUR  = 6'd10,
  parameter logic [5:0] DEF_MIN   = 6'd0,
  parameter logic [5:0] DEF_SEC   = 6'd0,
  parameter logic [7:0] CLEAN_SEC = 8'd180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       is_standby,
  input  logic       fan_on,
  input  logic       clean_req,
  input  logic       thr_load,
  input  logic [5:0] thr_hour,
  input  logic [5:0] thr_min,
  input  logic [5:0] thr_sec,
  output logic [5:0] work_hour,
  output logic [5:0] work_min,
  output logic [5:0] work_sec,
  output logic       warning,
  output logic       cleaning,
  output logic [7:0] clean_remain,
  output logic       clean_done,
  output logic       clean_abort
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAN = 1'b1;

  logic [0:0] state;
  logic [5:0] thr_hour_q;
  logic [5:0] thr_min_q;
  logic [5:0] thr_sec_q;

  logic work_sat;
  logic work_gt_thr;
  logic start;
  logic abort;
  logic finish;
  logic inc;

  assign work_sat = (work_hour == 6'd59) && (work_min == 6'd59) && (work_sec == 6'd59);
  assign start    = (state == S_IDLE) && clean_req && is_standby;
  assign abort    = (state == S_CLEAN) && !is_standby;
  // Abort takes priority over the final tick, so finish requires standby.
  assign finish   = (state == S_CLEAN) && is_standby && tick_1hz && (clean_remain == 8'd1);
  assign inc      = tick_1hz && fan_on && !cleaning && !work_sat;

  always_comb begin
    work_gt_thr = 1'b0;
    if (work_hour != thr_hour_q) begin
      work_gt_thr = work_hour > thr_hour_q;
    end else if (work_min != thr_min_q) begin
      work_gt_thr = work_min > thr_min_q;
    end else begin
      work_gt_thr = work_sec > thr_sec_q;
    end
  end

  // A zero field falls back to its own default, independently of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      thr_hour_q <= DEF_HOUR;
      thr_min_q  <= DEF_MIN;
      thr_sec_q  <= DEF_SEC;
    end else if (thr_load) begin
      thr_hour_q <= (thr_hour == 6'd0) ? DEF_HOUR : thr_hour;
      thr_min_q  <= (thr_min  == 6'd0) ? DEF_MIN  : thr_min;
      thr_sec_q  <= (thr_sec  == 6'd0) ? DEF_SEC  : thr_sec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_hour <= 6'd0;
      work_min  <= 6'd0;
      work_sec  <= 6'd0;
    end else if (finish) begin
      work_hour <= 6'd0;
      work_min  <= 6'd0;
      work_sec  <= 6'd0;
    end else if (inc) begin
      if (work_sec == 6'd59) begin
        work_sec <= 6'd0;
        if (work_min == 6'd59) begin
          work_min  <= 6'd0;
          work_hour <= work_hour + 6'd1;
        end else begin
          work_min <= work_min + 6'd1;
        end
      end else begin
        work_sec <= work_sec + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cleaning     <= 1'b0;
      clean_remain <= 8'd0;
      clean_done   <= 1'b0;
      clean_abort  <= 1'b0;
    end else begin
      clean_done  <= 1'b0;
      clean_abort <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_CLEAN;
            cleaning     <= 1'b1;
            clean_remain <= CLEAN_SEC;
          end
        end
        default: begin
          if (abort) begin
            state        <= S_IDLE;
            cleaning     <= 1'b0;
            clean_remain <= 8'd0;
            clean_abort  <= 1'b1;
          end else if (finish) begin
            state        <= S_IDLE;
            cleaning     <= 1'b0;
            clean_remain <= 8'd0;
            clean_done   <= 1'b1;
          end else if (tick_1hz) begin
            clean_remain <= clean_remain - 8'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      warning <= 1'b0;
    end else begin
      warning <= is_standby && !cleaning && work_gt_thr;
    end
  end

endmodule

// File: tb/tb_clean_scheduler.sv
// Directed bench for clean_scheduler with a 3-second self-clean cycle.
module tb_clean_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1hz;
  logic       is_standby;
  logic       fan_on;
  logic       clean_req;
  logic       thr_load;
  logic [5:0] thr_hour;
  logic [5:0] thr_min;
  logic [5:0] thr_sec;
  logic [5:0] work_hour;
  logic [5:0] work_min;
  logic [5:0] work_sec;
  logic       warning;
  logic       cleaning;
  logic [7:0] clean_remain;
  logic       clean_done;
  logic       clean_abort;

  int checks = 0;
  int failures = 0;

  clean_scheduler #(
    .DEF_HOUR (6'd10),
    .DEF_MIN  (6'd0),
    .DEF_SEC  (6'd0),
    .CLEAN_SEC(8'd3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_1hz    (tick_1hz),
    .is_standby  (is_standby),
    .fan_on      (fan_on),
    .clean_req   (clean_req),
    .thr_load    (thr_load),
    .thr_hour    (thr_hour),
    .thr_min     (thr_min),
    .thr_sec     (thr_sec),
    .work_hour   (work_hour),
    .work_min    (work_min),
    .work_sec    (work_sec),
    .warning     (warning),
    .cleaning    (cleaning),
    .clean_remain(clean_remain),
    .clean_done  (clean_done),
    .clean_abort (clean_abort)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_work(input string tag, input int h, input int m, input int s);
    chk({tag, "_hour"}, work_hour, h);
    chk({tag, "_min"},  work_min,  m);
    chk({tag, "_sec"},  work_sec,  s);
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; is_standby = 1'b0; fan_on = 1'b0; clean_req = 1'b0;
    thr_load = 1'b0; thr_hour = 6'd0; thr_min = 6'd0; thr_sec = 6'd0;
    cyc(); cyc();
    rst = 1'b0;

    // Reset state
    chk_work("rst_work", 0, 0, 0);
    chk("rst_thr_hour", dut.thr_hour_q, 10);
    chk("rst_thr_min", dut.thr_min_q, 0);
    chk("rst_thr_sec", dut.thr_sec_q, 0);
    chk("rst_warning", warning, 0);
    chk("rst_cleaning", cleaning, 0);
    chk("rst_remain", clean_remain, 0);
    chk("rst_done", clean_done, 0);
    chk("rst_abort", clean_abort, 0);

    // Accumulation with carries: 3661 s = 01:01:01
    fan_on = 1'b1;
    tick_1hz = 1'b1;
    repeat (3661) cyc();
    tick_1hz = 1'b0;
    chk_work("acc_3661", 1, 1, 1);
    fan_on = 1'b0;
    cyc();
    chk_work("acc_fan_off_hold", 1, 1, 1);

    // Saturation at 59:59:59
    force dut.work_hour = 6'd59;
    force dut.work_min  = 6'd59;
    force dut.work_sec  = 6'd58;
    cyc();
    release dut.work_hour;
    release dut.work_min;
    release dut.work_sec;
    cyc();
    chk_work("preload", 59, 59, 58);
    fan_on = 1'b1;
    pulse_tick();
    chk_work("sat_reach", 59, 59, 59);
    tick_1hz = 1'b1;
    repeat (4) cyc();
    tick_1hz = 1'b0;
    chk_work("sat_hold", 59, 59, 59);
    fan_on = 1'b0;

    // Threshold load and strict comparison
    do_reset();
    thr_load = 1'b1; thr_hour = 6'd1; thr_min = 6'd0; thr_sec = 6'd5;
    cyc();
    thr_load = 1'b0;
    chk("thr_hour_1", dut.thr_hour_q, 1);
    chk("thr_min_default", dut.thr_min_q, 0);
    chk("thr_sec_5", dut.thr_sec_q, 5);
    force dut.work_hour = 6'd1;
    force dut.work_min  = 6'd0;
    force dut.work_sec  = 6'd0;
    cyc();
    release dut.work_hour;
    release dut.work_min;
    release dut.work_sec;
    cyc();
    fan_on = 1'b1;
    tick_1hz = 1'b1;
    repeat (5) cyc();
    tick_1hz = 1'b0;
    chk_work("thr_work_eq", 1, 0, 5);
    is_standby = 1'b1;
    cyc(); cyc();
    chk("warn_equal", warning, 0);
    pulse_tick();
    chk("warn_latency", warning, 0);
    cyc();
    chk("warn_above", warning, 1);
    thr_load = 1'b1; thr_hour = 6'd0; thr_min = 6'd0; thr_sec = 6'd0;
    cyc();
    thr_load = 1'b0;
    chk("thr_zero_hour", dut.thr_hour_q, 10);
    chk("thr_zero_sec", dut.thr_sec_q, 0);
    cyc();
    chk("warn_drop", warning, 0);
    thr_load = 1'b1; thr_hour = 6'd0; thr_min = 6'd0; thr_sec = 6'd5;
    cyc();
    thr_load = 1'b0;
    chk("thr_field_hour_def", dut.thr_hour_q, 10);
    chk("thr_field_sec", dut.thr_sec_q, 5);
    fan_on = 1'b0; is_standby = 1'b0;

    // Normal self-clean cycle
    do_reset();
    fan_on = 1'b1;
    tick_1hz = 1'b1;
    repeat (6) cyc();
    tick_1hz = 1'b0;
    chk_work("pre_clean", 0, 0, 6);
    is_standby = 1'b1;
    clean_req = 1'b1;
    cyc();
    clean_req = 1'b0;
    chk("clean_start", cleaning, 1);
    chk("clean_start_remain", clean_remain, 3);
    pulse_tick();
    chk("clean_r2", clean_remain, 2);
    chk_work("clean_no_acc", 0, 0, 6);
    cyc();
    pulse_tick();
    chk("clean_r1", clean_remain, 1);
    cyc();
    chk("clean_done_idle", clean_done, 0);
    pulse_tick();
    chk("clean_done_pulse", clean_done, 1);
    chk("clean_end_cleaning", cleaning, 0);
    chk("clean_end_remain", clean_remain, 0);
    chk_work("clean_cleared", 0, 0, 0);
    cyc();
    chk("clean_done_one_cycle", clean_done, 0);

    // Abort mid-cycle
    pulse_tick();
    pulse_tick();
    chk_work("abort_pre", 0, 0, 2);
    clean_req = 1'b1;
    cyc();
    clean_req = 1'b0;
    pulse_tick();
    chk("abort_r2", clean_remain, 2);
    is_standby = 1'b0;
    cyc();
    chk("abort_pulse", clean_abort, 1);
    chk("abort_cleaning", cleaning, 0);
    chk("abort_remain", clean_remain, 0);
    chk_work("abort_work", 0, 0, 2);
    cyc();
    chk("abort_one_cycle", clean_abort, 0);
    clean_req = 1'b1;
    cyc();
    clean_req = 1'b0;
    chk("req_not_standby", cleaning, 0);
    chk("req_not_standby_remain", clean_remain, 0);

    // Tick and request together, then reset mid-cycle
    is_standby = 1'b1;
    tick_1hz = 1'b1; clean_req = 1'b1;
    cyc();
    tick_1hz = 1'b0; clean_req = 1'b0;
    chk_work("tick_req_acc", 0, 0, 3);
    chk("tick_req_remain", clean_remain, 3);
    pulse_tick();
    chk("tick_req_r2", clean_remain, 2);
    rst = 1'b1; is_standby = 1'b0;
    cyc();
    rst = 1'b0;
    chk("midrst_abort", clean_abort, 0);
    chk("midrst_cleaning", cleaning, 0);
    chk("midrst_remain", clean_remain, 0);
    chk("midrst_done", clean_done, 0);
    chk("midrst_warning", warning, 0);
    chk_work("midrst_work", 0, 0, 0);
    cyc();
    chk("midrst_no_late_abort", clean_abort, 0);

    // Abort wins over the final tick
    is_standby = 1'b1;
    pulse_tick();
    clean_req = 1'b1;
    cyc();
    clean_req = 1'b0;
    pulse_tick();
    pulse_tick();
    chk("race_r1", clean_remain, 1);
    tick_1hz = 1'b1; is_standby = 1'b0;
    cyc();
    tick_1hz = 1'b0;
    chk("race_abort", clean_abort, 1);
    chk("race_no_done", clean_done, 0);
    chk_work("race_work_kept", 0, 0, 1);
    fan_on = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
